// File: rtl/if_defs.sv
// Shared fetch-stage defaults and the prefetch FIFO entry layout.
package if_defs;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Entry is {instruction, pc_value}: instruction in the upper INSTR_W bits.
  function automatic int unsigned entry_width(input int unsigned instr_w,
                                               input int unsigned addr_w);
    return instr_w + addr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: combinational head read, synchronous clear, power-of-two depth.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC, credit-based request issue and in-flight
// tracking in front of a prefetch FIFO that is squashed on branch redirect.
module fetch_unit
  import if_defs::*;
#(
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter int unsigned        INSTR_W  = DEF_INSTR_W,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned        PC_STEP  = DEF_PC_STEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_value
);

  localparam int unsigned       ENTRY_W = entry_width(INSTR_W, ADDR_W);
  localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned       OCC_W   = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic [ADDR_W-1:0]  req_addr_reg;
  logic               inflight_reg;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   occupancy;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign out_valid = ~fifo_empty & ~branch_taken & ~reset;
  assign pop       = out_valid & out_ready;

  // Entries committed after this cycle, counting the response still in flight;
  // issuing only below DEPTH means a response never lands on a full FIFO.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_reg) - OCC_W'(pop);
  assign imem_req  = ~reset & ~branch_taken & (occupancy < OCC_W'(DEPTH));
  assign imem_addr = fetch_pc_reg;

  assign push       = inflight_reg & ~branch_taken & (~fifo_full | pop);
  assign push_entry = {imem_data, req_addr_reg + STEP};

  assign instruction = head_entry[ENTRY_W-1 -: INSTR_W];
  assign pc_value    = head_entry[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      inflight_reg <= 1'b0;
    end else begin
      req_addr_reg <= fetch_pc_reg;
      if (branch_taken) begin
        fetch_pc_reg <= branch_address;
        inflight_reg <= 1'b0;
      end else begin
        inflight_reg <= imem_req;
        if (imem_req) fetch_pc_reg <= fetch_pc_reg + STEP;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (branch_taken),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, branch squash,
// mid-run reset and PC wrap-around, against a mem[a] = a + 0x100 memory.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] pc_value;

  logic        w_reset;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_instruction;
  logic [31:0] w_pc_value;
  logic        w_branch_taken;
  logic [31:0] w_branch_address;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .clock(clock), .reset(reset), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .pc_value(pc_value)
  );

  fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
  ) dut_w (
    .clock(clock), .reset(w_reset), .branch_taken(w_branch_taken),
    .branch_address(w_branch_address), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .instruction(w_instruction), .pc_value(w_pc_value)
  );

  // Synchronous memory models with one cycle of read latency.
  always @(posedge clock) begin
    if (imem_req)   imem_data   <= imem_addr + 32'h100;
    if (w_imem_req) w_imem_data <= w_imem_addr + 32'h100;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect the head to be the instruction fetched from address a.
  task automatic expect_instr(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_instr"}, instruction, a + 32'h100);
    check({tag, "_pc"},    pc_value,    a + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_address = '0; out_ready = 1'b1;
    w_reset = 1'b1; w_out_ready = 1'b1; w_branch_taken = 1'b0; w_branch_address = '0;

    // Reset state and streaming latency
    step(); settle();
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_count", 32'(dut.fifo_count), 32'd0);
    step(); reset = 1'b0; settle();
    check("c0_req",  32'(imem_req), 32'd1);
    check("c0_addr", imem_addr,     32'h0);
    step(); settle();
    check("c1_valid", 32'(out_valid), 32'd0);
    step(); settle();
    for (int i = 0; i < 6; i++) begin
      expect_instr($sformatf("stream%0d", i), 32'(i * 4));
      step(); settle();
    end

    // Back-pressure: fill to DEPTH, then drain in order
    reset = 1'b1; out_ready = 1'b0; step(); reset = 1'b0; settle();
    repeat (10) step();
    settle();
    check("bp_count", 32'(dut.fifo_count), 32'd4);
    check("bp_req",   32'(imem_req),       32'd0);
    check("bp_pc",    imem_addr,           32'd16);
    out_ready = 1'b1; settle();
    for (int i = 0; i < 8; i++) begin
      expect_instr($sformatf("bp%0d", i), 32'(i * 4));
      step(); settle();
    end

    // Branch during streaming
    branch_taken = 1'b1; branch_address = 32'h200; settle();
    check("br0_valid", 32'(out_valid), 32'd0);
    check("br0_req",   32'(imem_req),  32'd0);
    step(); branch_taken = 1'b0; settle();
    check("br1_valid", 32'(out_valid), 32'd0);
    check("br1_req",   32'(imem_req),  32'd1);
    check("br1_addr",  imem_addr,      32'h200);
    step(); settle();
    check("br2_valid", 32'(out_valid), 32'd0);
    step(); settle();
    for (int i = 0; i < 4; i++) begin
      expect_instr($sformatf("br_stream%0d", i), 32'h200 + 32'(i * 4));
      step(); settle();
    end

    // Branch coinciding with a response arrival
    reset = 1'b1; out_ready = 1'b0; step(); reset = 1'b0; settle();
    repeat (4) step();
    settle();
    check("sq_count", 32'(dut.fifo_count),   32'd3);
    check("sq_infl",  32'(dut.inflight_reg), 32'd1);
    branch_taken = 1'b1; branch_address = 32'h400; settle();
    step(); branch_taken = 1'b0; settle();
    check("sq_cleared", 32'(dut.fifo_count), 32'd0);
    check("sq_req",     32'(imem_req),       32'd1);
    check("sq_addr",    imem_addr,           32'h400);
    out_ready = 1'b1; step(); settle();
    check("sq_t2_valid", 32'(out_valid), 32'd0);
    step(); settle();
    expect_instr("sq_first", 32'h400);

    // Branch with a full FIFO, held two cycles: the last target wins
    out_ready = 1'b0;
    repeat (8) step();
    settle();
    check("full_count", 32'(dut.fifo_count), 32'd4);
    check("full_req",   32'(imem_req),       32'd0);
    branch_taken = 1'b1; branch_address = 32'h700; settle();
    check("full_br_valid", 32'(out_valid), 32'd0);
    step(); branch_address = 32'h600; settle();
    check("full_br_count", 32'(dut.fifo_count), 32'd0);
    step(); branch_taken = 1'b0; out_ready = 1'b1; settle();
    check("dbl_req",  32'(imem_req), 32'd1);
    check("dbl_addr", imem_addr,     32'h600);
    step(); step(); settle();
    expect_instr("dbl_first", 32'h600);
    step(); settle();
    expect_instr("dbl_second", 32'h604);

    // Reset with 3 buffered entries and a request in flight
    reset = 1'b1; out_ready = 1'b0; step(); reset = 1'b0; settle();
    repeat (4) step();
    settle();
    check("mr_count", 32'(dut.fifo_count),   32'd3);
    check("mr_infl",  32'(dut.inflight_reg), 32'd1);
    reset = 1'b1; settle();
    check("mr_rst_valid", 32'(out_valid), 32'd0);
    check("mr_rst_req",   32'(imem_req),  32'd0);
    step(); reset = 1'b0; out_ready = 1'b1; settle();
    check("mr_c0_valid", 32'(out_valid),        32'd0);
    check("mr_c0_count", 32'(dut.fifo_count),   32'd0);
    check("mr_c0_addr",  imem_addr,             32'h0);
    step(); settle();
    check("mr_c1_valid", 32'(out_valid), 32'd0);
    step(); settle();
    expect_instr("mr_first", 32'h0);

    // PC wrap-around from RESET_PC = 0xFFFF_FFF8
    w_reset = 1'b0; settle();
    check("wr_c0_addr", w_imem_addr, 32'hFFFF_FFF8);
    check("wr_c0_req",  32'(w_imem_req), 32'd1);
    step(); settle();
    check("wr_c1_addr", w_imem_addr, 32'hFFFF_FFFC);
    step(); settle();
    check("wr_c2_addr",  w_imem_addr,          32'h0000_0000);
    check("wr_c2_valid", 32'(w_out_valid),     32'd1);
    check("wr_c2_instr", w_instruction,        32'h0000_00F8);
    check("wr_c2_pc",    w_pc_value,           32'hFFFF_FFFC);
    step(); settle();
    check("wr_c3_instr", w_instruction, 32'h0000_00FC);
    check("wr_c3_pc",    w_pc_value,    32'h0000_0000);
    step(); settle();
    check("wr_c4_instr", w_instruction, 32'h0000_0100);
    check("wr_c4_pc",    w_pc_value,    32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
